alu_32: RTL and testbench
=========================

ALU_32 -- requirements
Module: alu_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all values below assume 32.
REQ-002 clk  input  1  rising-edge clock; clocks the flag register only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 result  output  32  combinational signed operation result.
REQ-005 v_flag  output  1  registered signed-overflow flag.
REQ-006 n_flag  output  1  registered negative flag.
REQ-007 z_flag  output  1  registered zero flag.
REQ-008 op1  input  32  signed operand A.
REQ-009 op2  input  32  signed operand B.
REQ-010 alu_control_code  input  4  operation select.
REQ-011 Positional port order after clk, rst_n SHALL be result, v_flag, n_flag, z_flag, op1, op2, alu_control_code.

Function
REQ-012 The opcode map SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 NOR, 1100 NAND, 1101 XOR.
REQ-013 result SHALL be purely combinational from op1, op2 and alu_control_code, with zero-cycle latency.
REQ-014 ADD SHALL produce op1+op2, and SUB SHALL produce op1-op2, as two's-complement values modulo 2^32 with no saturation.
REQ-015 Logic ops (AND, OR, NOR, NAND, XOR) SHALL be bitwise on the full 32 bits.
REQ-016 Unlisted opcodes SHALL drive result = 0 and SHALL NOT update the flags.
REQ-017 On each rising clk edge with an ADD or SUB opcode, the flag register SHALL load V, N and Z computed from the current result.
REQ-018 On each rising clk edge with a logic or unlisted opcode, all three flags SHALL hold their previous values.
REQ-019 The N value loaded SHALL be result[31].
REQ-020 The Z value loaded SHALL be 1 when result == 0, and 0 otherwise.
REQ-021 ADD overflow SHALL be op1[31]==op2[31] && result[31]!=op1[31].
REQ-022 SUB overflow SHALL be op1[31]!=op2[31] && result[31]!=op1[31].
REQ-023 Flag outputs SHALL lag result by exactly one clock (registered, no bypass).
REQ-024 Operands and opcode changing between edges SHALL affect only result; flags change at edges only.

Reset
REQ-025 rst_n low SHALL immediately clear v_flag, n_flag and z_flag to 0, independent of clk.
REQ-026 result SHALL remain combinationally valid during reset.
REQ-027 The first flag update SHALL occur on the first rising clk edge after rst_n deasserts.
REQ-028 rst_n asserted mid-sequence SHALL discard held flags, returning them to 0.

Structure
REQ-029 Package alu_pkg SHALL hold the seven opcode localparams and WIDTH.
REQ-030 A single sub-module alu_addsub SHALL compute the sum/difference and the V, N, Z candidates.
REQ-031 The top level SHALL hold the logic mux and the flag register.

Verification
REQ-032 Logic: op1=0000ffff, op2=00ff00ff -> AND 000000ff, OR 00ffffff, NOR ff000000, XOR 00ffff00, NAND ffffff00.
REQ-033 ADD: (10,10)=20, (10,-10)=0, (-10,10)=0, (-10,-10)=-20. SUB: (10,10)=0, (10,-10)=20, (-10,10)=-20, (-10,-10)=0.
REQ-034 Z/N sequence: SUB 10-10, clock -> Z=1 N=0; SUB -10-10, clock -> Z=0 N=1; then five logic ops, each clocked -> flags unchanged.
REQ-035 ADD V cases: 7fffffff+7fffffff=fffffffe V=1; 80000000+80000000=00000000 V=1 Z=1; 11111111+11111111=22222222 V=0; 80000000+11111111=91111111 V=0.
REQ-036 SUB V cases: 7fffffff-80000001=fffffffe V=1; 80000000-80000000=0 V=0; 7fffffff-11111111=6eeeeeee V=0; 11111111-80000000=91111111 V=1.
REQ-037 Reset: with flags nonzero, assert rst_n low between edges -> flags 0 immediately; opcode 1111 -> result 0 and flags held.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the 32-bit ALU slice.
//   WIDTH   : default operand/result width.
//   OP_*    : 4-bit operation select codes driven on alu_control_code.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  // True for the two arithmetic codes, the only ones allowed to load flags.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// ----------------------------------------------------------------------------
// alu_addsub
// Combinational two's-complement adder/subtractor with flag candidates.
//   a, b  : signed operands (WIDTH bits)
//   sub   : 1 selects a - b, 0 selects a + b
//   sum   : result modulo 2^WIDTH, no saturation
//   v     : signed overflow for the selected operation
//   n     : sign bit of sum
//   z     : 1 when sum is all zeros
// ----------------------------------------------------------------------------
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             v,
  output logic             n,
  output logic             z
);

  logic sign_a;
  logic sign_b;
  logic sign_s;

  assign sum    = sub ? (a - b) : (a + b);
  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1];
  assign sign_s = sum[WIDTH-1];

  // Addition overflows when like-signed operands give a differently signed
  // sum; subtraction overflows when unlike-signed operands do the same.
  assign v = sub ? ((sign_a != sign_b) && (sign_s != sign_a))
                 : ((sign_a == sign_b) && (sign_s != sign_a));
  assign n = sign_s;
  assign z = (sum == '0);

endmodule

// File: rtl/alu_32.sv
// ----------------------------------------------------------------------------
// alu_32
// 32-bit ALU: combinational result, registered V/N/Z flags.
//   clk              : rising-edge clock for the flag register only
//   rst_n            : asynchronous active-low reset, clears the flags
//   result           : combinational operation result (zero-cycle latency)
//   v_flag/n_flag/z_flag : flags loaded on ADD/SUB edges, held otherwise
//   op1, op2         : signed operands
//   alu_control_code : operation select (see alu_pkg OP_*)
// Unlisted codes drive result to zero and leave the flags untouched.
// ----------------------------------------------------------------------------
module alu_32 #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] result,
  output logic             v_flag,
  output logic             n_flag,
  output logic             z_flag,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_control_code
);

  import alu_pkg::*;

  logic [WIDTH-1:0] arith_sum;
  logic             arith_v;
  logic             arith_n;
  logic             arith_z;
  logic             load_flags;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (op1),
    .b   (op2),
    .sub (alu_control_code == OP_SUB),
    .sum (arith_sum),
    .v   (arith_v),
    .n   (arith_n),
    .z   (arith_z)
  );

  always_comb begin
    result = '0;
    case (alu_control_code)
      OP_AND:  result = op1 & op2;
      OP_OR:   result = op1 | op2;
      OP_ADD:  result = arith_sum;
      OP_SUB:  result = arith_sum;
      OP_NOR:  result = ~(op1 | op2);
      OP_NAND: result = ~(op1 & op2);
      OP_XOR:  result = op1 ^ op2;
      default: result = '0;
    endcase
  end

  assign load_flags = is_arith(alu_control_code);

  // Flags reflect the result present at the edge, so they trail result by
  // one clock; there is intentionally no combinational bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag <= 1'b0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (load_flags) begin
      v_flag <= arith_v;
      n_flag <= arith_n;
      z_flag <= arith_z;
    end
  end

endmodule

// File: tb/tb_alu_32.sv
// ----------------------------------------------------------------------------
// tb_alu_32
// Directed self-checking bench for alu_32 with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_alu_32;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_NOR  = 4'b1001;
  localparam logic [3:0] C_NAND = 4'b1100;
  localparam logic [3:0] C_XOR  = 4'b1101;
  localparam logic [3:0] C_BAD  = 4'b1111;

  logic        clk;
  logic        rst_n;
  logic [31:0] result;
  logic        v_flag;
  logic        n_flag;
  logic        z_flag;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_control_code;

  int pass_cnt;
  int check_cnt;

  alu_32 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .result           (result),
    .v_flag           (v_flag),
    .n_flag           (n_flag),
    .z_flag           (z_flag),
    .op1              (op1),
    .op2              (op2),
    .alu_control_code (alu_control_code)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after a rising edge, well away
  // from the next one; outputs are sampled before the next edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    alu_control_code = op;
    op1 = a;
    op2 = b;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(C_AND, 32'h0000ffff, 32'h00ff00ff);
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b000)
      $display("FAIL reset_flags: got vnz=%b expected 000", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    check_cnt++;
    if (result !== 32'h000000ff)
      $display("FAIL reset_result: got %h expected 000000ff", result);
    else pass_cnt++;
    // Arithmetic op during reset must not load flags.
    apply(C_SUB, 32'd10, 32'd10);
    step();
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b000)
      $display("FAIL reset_hold: got vnz=%b expected 000", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // First edge after release loads Z from 10-10.
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b001)
      $display("FAIL first_update: got vnz=%b expected 001", {v_flag, n_flag, z_flag});
    else pass_cnt++;
  endtask

  task automatic test_logic();
    logic [3:0]  ops [5];
    logic [31:0] exp [5];
    ops[0] = C_AND;  exp[0] = 32'h000000ff;
    ops[1] = C_OR;   exp[1] = 32'h00ffffff;
    ops[2] = C_NOR;  exp[2] = 32'hff000000;
    ops[3] = C_XOR;  exp[3] = 32'h00ffff00;
    ops[4] = C_NAND; exp[4] = 32'hffffff00;
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], 32'h0000ffff, 32'h00ff00ff);
      check_cnt++;
      if (result !== exp[i])
        $display("FAIL logic_op%0d: got %h expected %h", i, result, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_arith();
    logic [3:0]  ops [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    ops[0] = C_ADD; a[0] = 32'd10;  b[0] = 32'd10;  exp[0] = 32'd20;
    ops[1] = C_ADD; a[1] = 32'd10;  b[1] = -32'd10; exp[1] = 32'd0;
    ops[2] = C_ADD; a[2] = -32'd10; b[2] = 32'd10;  exp[2] = 32'd0;
    ops[3] = C_ADD; a[3] = -32'd10; b[3] = -32'd10; exp[3] = -32'd20;
    ops[4] = C_SUB; a[4] = 32'd10;  b[4] = 32'd10;  exp[4] = 32'd0;
    ops[5] = C_SUB; a[5] = 32'd10;  b[5] = -32'd10; exp[5] = 32'd20;
    ops[6] = C_SUB; a[6] = -32'd10; b[6] = 32'd10;  exp[6] = -32'd20;
    ops[7] = C_SUB; a[7] = -32'd10; b[7] = -32'd10; exp[7] = 32'd0;
    for (int i = 0; i < 8; i++) begin
      apply(ops[i], a[i], b[i]);
      check_cnt++;
      if (result !== exp[i])
        $display("FAIL arith%0d: got %h expected %h", i, result, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zn_sequence();
    logic [3:0] ops [5];
    ops[0] = C_AND; ops[1] = C_OR; ops[2] = C_NOR; ops[3] = C_XOR; ops[4] = C_NAND;
    apply(C_SUB, 32'd10, 32'd10);
    step();
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b001)
      $display("FAIL zn_zero: got vnz=%b expected 001", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    // Flags must not follow result between edges.
    apply(C_SUB, -32'd10, 32'd10);
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b001)
      $display("FAIL zn_lag: got vnz=%b expected 001", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    step();
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b010)
      $display("FAIL zn_neg: got vnz=%b expected 010", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], 32'h00000000, 32'h00000000);
      step();
      check_cnt++;
      if ({v_flag, n_flag, z_flag} !== 3'b010)
        $display("FAIL zn_hold%0d: got vnz=%b expected 010", i, {v_flag, n_flag, z_flag});
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  ops [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    logic [2:0]  vnz [8];
    ops[0] = C_ADD; a[0] = 32'h7fffffff; b[0] = 32'h7fffffff; exp[0] = 32'hfffffffe; vnz[0] = 3'b110;
    ops[1] = C_ADD; a[1] = 32'h80000000; b[1] = 32'h80000000; exp[1] = 32'h00000000; vnz[1] = 3'b101;
    ops[2] = C_ADD; a[2] = 32'h11111111; b[2] = 32'h11111111; exp[2] = 32'h22222222; vnz[2] = 3'b000;
    ops[3] = C_ADD; a[3] = 32'h80000000; b[3] = 32'h11111111; exp[3] = 32'h91111111; vnz[3] = 3'b010;
    ops[4] = C_SUB; a[4] = 32'h7fffffff; b[4] = 32'h80000001; exp[4] = 32'hfffffffe; vnz[4] = 3'b110;
    ops[5] = C_SUB; a[5] = 32'h80000000; b[5] = 32'h80000000; exp[5] = 32'h00000000; vnz[5] = 3'b001;
    ops[6] = C_SUB; a[6] = 32'h7fffffff; b[6] = 32'h11111111; exp[6] = 32'h6eeeeeee; vnz[6] = 3'b000;
    ops[7] = C_SUB; a[7] = 32'h11111111; b[7] = 32'h80000000; exp[7] = 32'h91111111; vnz[7] = 3'b110;
    for (int i = 0; i < 8; i++) begin
      apply(ops[i], a[i], b[i]);
      check_cnt++;
      if (result !== exp[i])
        $display("FAIL ovf_result%0d: got %h expected %h", i, result, exp[i]);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({v_flag, n_flag, z_flag} !== vnz[i])
        $display("FAIL ovf_flags%0d: got vnz=%b expected %b", i, {v_flag, n_flag, z_flag}, vnz[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_unlisted_and_reset();
    // Establish V=1 N=1.
    apply(C_ADD, 32'h7fffffff, 32'h7fffffff);
    step();
    apply(C_BAD, 32'h12345678, 32'h9abcdef0);
    check_cnt++;
    if (result !== 32'h00000000)
      $display("FAIL unlisted_result: got %h expected 00000000", result);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b110)
      $display("FAIL unlisted_hold: got vnz=%b expected 110", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    // Mid-cycle reset clears flags without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b000)
      $display("FAIL async_reset: got vnz=%b expected 000", {v_flag, n_flag, z_flag});
    else pass_cnt++;
    apply(C_XOR, 32'hf0f0f0f0, 32'h0f0f0f0f);
    check_cnt++;
    if (result !== 32'hffffffff)
      $display("FAIL reset_comb: got %h expected ffffffff", result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    apply(C_BAD, 32'h80000000, 32'h80000000);
    step();
    check_cnt++;
    if ({v_flag, n_flag, z_flag} !== 3'b000)
      $display("FAIL post_reset_hold: got vnz=%b expected 000", {v_flag, n_flag, z_flag});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    check_cnt = 0;
    rst_n = 1'b0;
    op1 = '0;
    op2 = '0;
    alu_control_code = C_AND;
    test_reset();
    test_logic();
    test_arith();
    test_zn_sequence();
    test_overflow();
    test_unlisted_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
